shuffle_feed_ctrl: RTL and testbench
====================================

SHUFFLE_FEED_CTRL -- requirements
Module: shuffle_feed_ctrl

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 14: coefficient width.
- REQ-002 SHALL have parameter NCOEF, default 256: coefficients per transfer.
- REQ-003 SHALL have parameter ADDR_W, default 8: read address width, with 2^ADDR_W >= NCOEF.
- REQ-004 SHALL have parameter DEPTH, default 8: delay-line depth of the downstream shifter stage, with DEPTH >= 1.
- REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-007 SHALL have port start, input, 1 bit: transfer request.
- REQ-008 SHALL have port rd_en, output, 1 bit: coefficient memory read strobe.
- REQ-009 SHALL have port rd_addr, output, ADDR_W bits: coefficient memory address.
- REQ-010 SHALL have port rd_data, input, DATA_WIDTH bits: memory data, valid in the cycle after rd_en.
- REQ-011 SHALL have port feed_data, output, DATA_WIDTH bits: coefficient driven into the shifter.
- REQ-012 SHALL have port feed_valid, output, 1 bit: feed_data qualifier.
- REQ-013 SHALL have port out_valid, output, 1 bit: feed_valid delayed by DEPTH cycles, aligned with shifter output.
- REQ-014 SHALL have port out_last, output, 1 bit: marks the NCOEF-th out_valid.
- REQ-015 SHALL have port busy, output, 1 bit: transfer in progress.
- REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
- REQ-017 SHALL have port stall, input, 1 bit: read hold request; present only with FEED_STALL_EN.

Function
- REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
- REQ-019 SHALL move IDLE->READ when start=1 is sampled in IDLE; start SHALL be ignored in all other states.
- REQ-020 SHALL, in READ cycle k (k=0 is the first READ cycle), drive rd_en=1 and rd_addr=k, for k=0..NCOEF-1.
- REQ-021 SHALL register rd_data into feed_data and assert feed_valid two cycles after the corresponding rd_en cycle.
- REQ-022 SHALL hold feed_data at its last value when feed_valid=0.
- REQ-023 SHALL generate out_valid through a DEPTH-stage valid shift pipeline that is never frozen.
- REQ-024 SHALL move READ->DRAIN after issuing address NCOEF-1.
- REQ-025 SHALL count out_valid pulses; on the NCOEF-th pulse it SHALL assert out_last in the same cycle and move DRAIN->DONE.
- REQ-026 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
- REQ-027 SHALL drive busy=1 in READ and DRAIN, and busy=0 in IDLE and DONE.
- REQ-028 SHALL drive rd_en=0 outside READ, with rd_addr holding its last value.
- REQ-029 SHALL give nominal timing, with no stall: out_valid in cycles 2+DEPTH .. NCOEF+1+DEPTH; done in cycle NCOEF+2+DEPTH.
- REQ-030 SHALL, when start is asserted in the done cycle, ignore it; a new start is accepted from the following IDLE cycle.

Reset
- REQ-031 SHALL, on rst_n=0 at any time including mid-transfer, immediately force the FSM to IDLE.
- REQ-032 SHALL, on reset, clear rd_en, rd_addr, feed_data, feed_valid, the valid pipeline, out_valid, out_last, busy, done and all counters to 0.
- REQ-033 SHALL, after reset release, stay in IDLE until start is sampled.

Configuration
- REQ-034 SHALL gate the stall feature with macro FEED_STALL_EN.
- REQ-035 SHALL, when FEED_STALL_EN is defined, provide the stall port; stall=1 in READ forces rd_en=0, holds rd_addr and the read index, and inserts feed_valid bubbles that propagate to out_valid; DRAIN still ends on the NCOEF-th out_valid.
- REQ-036 SHALL, when FEED_STALL_EN is undefined, omit the stall port, with READ lasting exactly NCOEF cycles.

Verification (bench: NCOEF=16, DEPTH=8, ADDR_W=4, memory returns data = 100+addr)
- REQ-037 SHALL cover: start pulse, with start sampled at the edge ending cycle -1 -> rd_addr 0..15 in cycles 0..15; feed_data 100..115 in cycles 2..17; out_valid in cycles 10..25; out_last in cycle 25; done in cycle 26; busy high in cycles 0..25.
- REQ-038 SHALL cover: start held high for 40 cycles -> exactly 2 transfers, with the second first rd_en in cycle 28.
- REQ-039 SHALL cover: rst_n low in cycle 7 -> all outputs 0 in that cycle; no done; a new start then yields a full 16-coefficient transfer.
- REQ-040 SHALL cover: FEED_STALL_EN defined, stall=1 in cycles 4..6 -> rd_addr 4 held, 3 out_valid bubbles, out_last in cycle 28, done in cycle 29, 16 out_valid pulses total.
- REQ-041 SHALL cover: start pulsed during DRAIN and during the done cycle -> ignored, with no extra rd_en.

Source files
------------

// File: rtl/shuffle_feed_ctrl.sv
// Coefficient feeder: streams NCOEF words from memory into a DEPTH-deep shifter.
// Define FEED_STALL_EN to add the stall input that pauses memory reads.
module shuffle_feed_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int NCOEF      = 256,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef FEED_STALL_EN
  input  logic                  stall,
`endif
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] feed_data,
  output logic                  feed_valid,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(NCOEF + 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NCOEF - 1);
  localparam logic [CW-1:0]     LAST_C = CW'(NCOEF - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rden_q;
  logic                    fv_q;
  logic [DATA_WIDTH-1:0]   fd_q;
  logic [DEPTH-1:0]        vld_q;
  logic                    hold;

`ifdef FEED_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign rd_addr    = addr_q;
  assign feed_data  = fd_q;
  assign feed_valid = fv_q;
  assign out_valid  = vld_q[DEPTH-1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    out_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      READ: begin
        busy  = 1'b1;
        rd_en = !hold;
        if (!hold) begin
          if (addr_q == LAST_A) state_d = DRAIN;
          else addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && cnt_q == LAST_C) begin
          out_last = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pulses may already emerge while reads are still being issued
    if (busy && out_valid) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rden_q  <= 1'b0;
      fv_q    <= 1'b0;
      fd_q    <= '0;
      vld_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rden_q   <= rd_en;
      fv_q     <= rden_q;
      if (rden_q) fd_q <= rd_data;
      vld_q[0] <= fv_q;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

endmodule

// File: tb/tb_shuffle_feed_ctrl.sv
// Scoreboard bench for shuffle_feed_ctrl (NCOEF=16, DEPTH=8, mem = 100+addr).
// Stall scenario runs only when FEED_STALL_EN is defined.
module tb_shuffle_feed_ctrl;

  localparam int DW = 14;
  localparam int NC = 16;
  localparam int AW = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
`ifdef FEED_STALL_EN
  logic          stall = 1'b0;
`endif
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] feed_data;
  logic          feed_valid;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= DW'(100 + int'(rd_addr));

  shuffle_feed_ctrl #(
    .DATA_WIDTH(DW),
    .NCOEF     (NC),
    .ADDR_W    (AW),
    .DEPTH     (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef FEED_STALL_EN
    .stall     (stall),
`endif
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .feed_data (feed_data),
    .feed_valid(feed_valid),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic test_reset();
    logic [DW+AW+6:0] outs;
    rst_n = 1'b0;
    #12;
    outs = {rd_en, rd_addr, feed_data, feed_valid, out_valid, out_last, busy, done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rd_en, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle c%0d: rd_en/busy/done %b want 000", c, {rd_en, busy, done});
      end
    end
  endtask

  // s0/sl: stall window start and length; pulses: extra starts in DRAIN and DONE
  task automatic test_transfer(input int s0, input int sl, input bit pulses);
    int   iss[NC];
    bit   er[0:79];
    int   ea[0:79];
    int   lastc, donec, novl;
    bit   efv, eov;
    logic [DW-1:0] exp;
    for (int c = 0; c < 80; c++) begin
      er[c] = 1'b0;
      ea[c] = 0;
    end
    for (int a = 0; a < NC; a++) begin
      iss[a] = (sl > 0 && a >= s0) ? a + sl : a;
      er[iss[a]] = 1'b1;
      ea[iss[a]] = a;
    end
    for (int c = s0; c < s0 + sl; c++) ea[c] = s0;
    lastc = iss[NC-1] + 2 + DP;
    donec = lastc + 1;
    for (int c = iss[NC-1] + 1; c < 80; c++) ea[c] = NC - 1;
    sb.delete();
    for (int a = 0; a < NC; a++) sb.push_back(DW'(100 + a));
    novl = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c <= donec + 2; c++) begin
      @(posedge clk); #1;
      start = pulses && (c == 20 || c == donec);
`ifdef FEED_STALL_EN
      stall = (c >= s0 && c < s0 + sl);
`endif
      @(negedge clk);
      checks++;
      if (rd_en !== er[c]) begin
        errors++;
        $display("FAIL rd_en c%0d: got %b want %b", c, rd_en, er[c]);
      end
      if (c <= donec) begin
        checks++;
        if (rd_addr !== AW'(ea[c])) begin
          errors++;
          $display("FAIL rd_addr c%0d: got %0d want %0d", c, rd_addr, ea[c]);
        end
      end
      efv = (c >= 2) ? er[c-2] : 1'b0;
      checks++;
      if (feed_valid !== efv) begin
        errors++;
        $display("FAIL feed_valid c%0d: got %b want %b", c, feed_valid, efv);
      end
      if (feed_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL feed_data c%0d: got %0d want none", c, feed_data);
        end else begin
          exp = sb.pop_front();
          if (feed_data !== exp) begin
            errors++;
            $display("FAIL feed_data c%0d: got %0d want %0d", c, feed_data, exp);
          end
        end
      end
      eov = (c >= 2 + DP) ? er[c-2-DP] : 1'b0;
      checks++;
      if (out_valid !== eov) begin
        errors++;
        $display("FAIL out_valid c%0d: got %b want %b", c, out_valid, eov);
      end
      if (out_valid === 1'b1) novl++;
      checks++;
      if ({out_last, done, busy} !== {c == lastc, c == donec, c <= lastc}) begin
        errors++;
        $display("FAIL last/done/busy c%0d: got %b want %b", c,
                 {out_last, done, busy}, {c == lastc, c == donec, c <= lastc});
      end
    end
    start = 1'b0;
`ifdef FEED_STALL_EN
    stall = 1'b0;
`endif
    checks++;
    if (novl != NC) begin
      errors++;
      $display("FAIL out_valid_count: got %0d want %0d", novl, NC);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    checks++;
    if (feed_data !== DW'(100 + NC - 1)) begin
      errors++;
      $display("FAIL feed_hold: got %0d want %0d", feed_data, 100 + NC - 1);
    end
  endtask

  task automatic test_back_to_back();
    int nrd = 0;
    int ndone = 0;
    int first2 = -1;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1 start = (c < 39);
      @(negedge clk);
      if (rd_en === 1'b1) nrd++;
      if (rd_en === 1'b1 && ndone == 1 && first2 < 0) first2 = c;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    checks++;
    if (nrd != 2 * NC) begin
      errors++;
      $display("FAIL b2b_reads: got %0d want %0d", nrd, 2 * NC);
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b_done: got %0d want 2", ndone);
    end
    checks++;
    if (first2 != 28) begin
      errors++;
      $display("FAIL b2b_second_start: got %0d want 28", first2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW+AW+6:0] outs;
    int ndone = 0;
    int nbusy = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (rd_addr !== AW'(6) || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: addr %0d busy %b want 6 1", rd_addr, busy);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    outs = {rd_en, rd_addr, feed_data, feed_valid, out_valid, out_last, busy, done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs: got %h want 0", outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy !== 1'b0 || rd_en !== 1'b0) nbusy++;
    end
    checks++;
    if (ndone != 0 || nbusy != 0) begin
      errors++;
      $display("FAIL mid_after: done %0d active %0d want 0 0", ndone, nbusy);
    end
    test_transfer(0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_transfer(0, 0, 1'b0);
    test_transfer(0, 0, 1'b1);
    test_back_to_back();
    test_reset_mid();
`ifdef FEED_STALL_EN
    test_transfer(4, 3, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
